pipeline_stage0: RTL and testbench

Instruction-fetch stage that sits directly upstream of pipeline stage 1. It owns the program counter and drives the memory address. Each cycle it latches one opcode/operand byte from the memory data bus into the pipe register that feeds stage 1's PipeIn. It inserts NOP bubbles on boot, on bus request, on fetch suppress from stage 1, and on PC redirect (jump).

---
 rtl/pipeline_stage0.sv | 120 ++++++++++++
 tb/tb_pipeline_stage0.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage0.sv
// Instruction-fetch stage: owns the PC, drives the memory address and feeds one
// byte per clock (or a NOP bubble) into the pipe register read by stage 1.
module pipeline_stage0 #(
    parameter int unsigned          ADDR_W       = 16,
    parameter logic [7:0]           NOP_OPCODE   = 8'h00,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
    parameter int unsigned          BOOT_NOPS    = 3
) (
    input  logic              ClockIn,
    input  logic              Reset,
    input  logic [7:0]        MemData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic              BusRequest,
    input  logic              FetchSuppress,
    input  logic              PcLoad,
    input  logic [ADDR_W-1:0] PcLoadValue,
    output logic [7:0]        PipeOut,
    output logic              PipeValid,
    output logic [ADDR_W-1:0] Pc
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_NOPS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_bootcnt;
    logic [3:0]        w_bootcnt_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [7:0]        r_pipe;
    logic [7:0]        w_pipe_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_mem_read;
    logic              w_mem_read_nxt;

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state    <= ST_BOOT;
            r_bootcnt  <= BOOT_INIT;
            r_pc       <= RESET_VECTOR;
            r_pipe     <= NOP_OPCODE;
            r_valid    <= 1'b0;
            r_mem_read <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bootcnt  <= w_bootcnt_nxt;
            r_pc       <= w_pc_nxt;
            r_pipe     <= w_pipe_nxt;
            r_valid    <= w_valid_nxt;
            r_mem_read <= w_mem_read_nxt;
        end
    end

    // Every path defaults to a bubble with the bus released; only a real fetch
    // overrides the pipe byte, and a redirect wins over PC hold in every state.
    always_comb begin
        w_state_nxt    = r_state;
        w_bootcnt_nxt  = r_bootcnt;
        w_pc_nxt       = r_pc;
        w_pipe_nxt     = NOP_OPCODE;
        w_valid_nxt    = 1'b0;
        w_mem_read_nxt = 1'b0;

        if (PcLoad) begin
            w_pc_nxt = PcLoadValue;
        end

        case (r_state)
            ST_BOOT: begin
                if (r_bootcnt <= 4'd1) begin
                    w_state_nxt    = ST_RUN;
                    w_mem_read_nxt = 1'b1;
                end else begin
                    w_bootcnt_nxt  = r_bootcnt - 4'd1;
                end
            end

            ST_RUN: begin
                if (BusRequest) begin
                    w_state_nxt    = ST_HOLD;
                end else if (PcLoad) begin
                    w_mem_read_nxt = 1'b1;
                end else if (FetchSuppress || !r_mem_read) begin
                    w_mem_read_nxt = !FetchSuppress;
                end else begin
                    w_pipe_nxt     = MemData;
                    w_valid_nxt    = 1'b1;
                    w_pc_nxt       = r_pc + 1'b1;
                    w_mem_read_nxt = 1'b1;
                end
            end

            ST_HOLD: begin
                if (!BusRequest) begin
                    w_state_nxt    = ST_RUN;
                    w_mem_read_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign MemAddr   = r_pc;
    assign Pc        = r_pc;
    assign MemRead   = r_mem_read;
    assign PipeOut   = r_pipe;
    assign PipeValid = r_valid;

endmodule

// File: tb/tb_pipeline_stage0.sv
// Scoreboard bench for pipeline_stage0: expected fetched bytes are queued as
// stimulus is driven and consumed whenever PipeValid is seen high.
module tb_pipeline_stage0;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  MemData;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic        BusRequest;
    logic        FetchSuppress;
    logic        PcLoad;
    logic [15:0] PcLoadValue;
    logic [7:0]  PipeOut;
    logic        PipeValid;
    logic [15:0] Pc;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    pipeline_stage0 #(
        .ADDR_W      (16),
        .NOP_OPCODE  (8'h00),
        .RESET_VECTOR(16'h0000),
        .BOOT_NOPS   (3)
    ) dut (
        .ClockIn      (clk),
        .Reset        (Reset),
        .MemData      (MemData),
        .MemAddr      (MemAddr),
        .MemRead      (MemRead),
        .BusRequest   (BusRequest),
        .FetchSuppress(FetchSuppress),
        .PcLoad       (PcLoad),
        .PcLoadValue  (PcLoadValue),
        .PipeOut      (PipeOut),
        .PipeValid    (PipeValid),
        .Pc           (Pc)
    );

    function automatic logic [7:0] mem(input logic [15:0] a);
        case (a)
            16'h0000: mem = 8'hAA;
            16'h0001: mem = 8'hBB;
            16'h0002: mem = 8'hCC;
            default:  mem = a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    always_comb MemData = mem(MemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [15:0] lo, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(mem(16'(lo + i)));
    endtask

    task automatic wait_pc(input logic [15:0] target, input int unsigned budget);
        int unsigned k = 0;
        while (Pc !== target && k < budget) begin
            tick();
            k++;
        end
        check("wait_pc", Pc, target);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (PipeValid === 1'b1) begin
                if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
                else check("pipe_byte", PipeOut, exp_q.pop_front());
            end else begin
                check("bubble_nop", PipeOut, 8'h00);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; BusRequest = 1'b0; FetchSuppress = 1'b0;
        PcLoad = 1'b0; PcLoadValue = 16'h0000;

        // 1: reset, boot bubbles, first fetches
        tick(); tick();
        mon_en = 1'b1;
        check("rst_pc", Pc, 16'h0000);
        check("rst_memread", MemRead, 0);
        check("rst_valid", PipeValid, 0);
        check("rst_pipe", PipeOut, 8'h00);
        Reset = 1'b0;
        push_range(16'h0000, 16);
        tick(); check("boot1_valid", PipeValid, 0); check("boot1_memread", MemRead, 0);
        tick(); check("boot2_valid", PipeValid, 0); check("boot2_memread", MemRead, 0);
        tick(); check("boot3_valid", PipeValid, 0); check("boot3_memread", MemRead, 1);
        check("first_addr", MemAddr, 16'h0000);
        tick(); check("addr1", MemAddr, 16'h0001); check("first_byte", PipeOut, 8'hAA);
        tick(); check("addr2", MemAddr, 16'h0002); check("second_byte", PipeOut, 8'hBB);
        wait_pc(16'h0010, 40);

        // 2: bus request held 4 cycles
        BusRequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_pc", Pc, 16'h0010);
            check("hold_memread", MemRead, 0);
            check("hold_valid", PipeValid, 0);
        end
        BusRequest = 1'b0;
        push_range(16'h0010, 16);
        tick(); check("hold_exit_memread", MemRead, 1); check("hold_exit_pc", Pc, 16'h0010);
        wait_pc(16'h0020, 40);

        // 3: one-cycle fetch suppress
        FetchSuppress = 1'b1;
        tick();
        FetchSuppress = 1'b0;
        check("fs_valid", PipeValid, 0);
        check("fs_pc", Pc, 16'h0020);
        check("fs_memread", MemRead, 0);
        push_range(16'h0020, 16'h30);
        wait_pc(16'h0050, 80);

        // 4: redirect flushes the in-flight byte
        PcLoad = 1'b1; PcLoadValue = 16'h1234;
        tick();
        PcLoad = 1'b0;
        check("jmp_pc", Pc, 16'h1234);
        check("jmp_addr", MemAddr, 16'h1234);
        check("jmp_valid", PipeValid, 0);
        check("jmp_memread", MemRead, 1);
        push_range(16'h1234, 1);
        tick();
        check("jmp_byte", PipeOut, mem(16'h1234));
        check("jmp_byte_valid", PipeValid, 1);
        check("jmp_pc_inc", Pc, 16'h1235);

        // 5: PC wrap
        PcLoad = 1'b1; PcLoadValue = 16'hFFFE;
        tick();
        PcLoad = 1'b0;
        push_range(16'hFFFE, 3);
        tick();
        tick(); check("wrap_pc", Pc, 16'h0000); check("wrap_addr", MemAddr, 16'h0000);
        tick(); check("wrap_pc_inc", Pc, 16'h0001);

        // 6: redirect together with bus request, then redirect inside HOLD
        PcLoad = 1'b1; PcLoadValue = 16'h0AB0; BusRequest = 1'b1;
        tick();
        PcLoad = 1'b0;
        check("ldbr_pc", Pc, 16'h0AB0);
        check("ldbr_memread", MemRead, 0);
        check("ldbr_valid", PipeValid, 0);
        PcLoad = 1'b1; PcLoadValue = 16'h0ABC;
        tick();
        PcLoad = 1'b0;
        check("hold_ld_pc", Pc, 16'h0ABC);
        check("hold_ld_memread", MemRead, 0);
        tick(); check("hold_still", MemRead, 0);
        BusRequest = 1'b0;
        push_range(16'h0ABC, 2);
        tick(); check("ldbr_resume", MemRead, 1); check("ldbr_resume_pc", Pc, 16'h0ABC);
        tick(); check("ldbr_pc1", Pc, 16'h0ABD);
        tick(); check("ldbr_pc2", Pc, 16'h0ABE);

        // 7: reset during HOLD restarts boot
        BusRequest = 1'b1;
        tick();
        Reset = 1'b1;
        tick();
        check("mrst_pc", Pc, 16'h0000);
        check("mrst_memread", MemRead, 0);
        check("mrst_valid", PipeValid, 0);
        Reset = 1'b0; BusRequest = 1'b0;
        push_range(16'h0000, 2);
        tick(); check("reboot1", MemRead, 0);
        tick(); check("reboot2", MemRead, 0);
        tick(); check("reboot3", MemRead, 1); check("reboot_addr", MemAddr, 16'h0000);
        tick(); check("reboot_b0", PipeOut, 8'hAA);
        tick(); check("reboot_b1", PipeOut, 8'hBB);
        Reset = 1'b1;
        tick(); tick();
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
